aes_state_reader: RTL and testbench

Read-side sequencer for the byte-wide 16-entry state RAM of the iterative AES core. On `start` it issues 16 read addresses in linear, ShiftRows or InvShiftRows order and absorbs the RAM's one-cycle read latency. It delivers bytes on a valid/ready stream to the round datapath (S-box/MixColumns), and optionally assembles 32-bit columns. It is the counterpart of the state write-port multiplexer: the write mux selects what enters the state RAM, and this block drains it.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_skid_buf.sv | 53 +++++
 rtl/aes_state_reader.sv | 143 ++++++++++++++
 tb/tb_aes_state_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the iterative AES core's state RAM.
//   aes_rd_mode_t   read ordering (linear / ShiftRows / InvShiftRows)
//   aes_rd_state_t  reader FSM states
//   AES_STATE_BYTES bytes in the AES state
//   aes_perm_addr   output index -> state RAM address for a given mode; the
//                   write path can reuse it to place bytes in permuted order.
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    RD_LINEAR   = 2'b00,
    RD_SHIFT    = 2'b01,
    RD_INVSHIFT = 2'b10
  } aes_rd_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } aes_rd_state_t;

  // State is column-major: index k = 4c + r. The column index is 2 bits
  // wide, so the sum and the difference wrap mod 4 without extra masking.
  // Mode 2'b11 falls through to linear order.
  function automatic logic [3:0] aes_perm_addr(input logic [1:0] mode,
                                               input logic [3:0] idx);
    logic [1:0] c;
    logic [1:0] r;
    c = idx[3:2];
    r = idx[1:0];
    case (mode)
      RD_SHIFT:    aes_perm_addr = {2'(c + r), r};
      RD_INVSHIFT: aes_perm_addr = {2'(c - r), r};
      default:     aes_perm_addr = idx;
    endcase
  endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// aes_skid_buf: 2-entry, 8-bit FIFO between the state RAM read data and the
// output stream.
//   clk, rst_n  clock, synchronous active-low reset (clears storage too)
//   push, din   write one byte (accepted when not full, or full with pop)
//   pop, dout   dout is the head entry; pop removes it (ignored when empty)
//   full, empty, count  occupancy (0..2)
module aes_skid_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [1:0][7:0] mem;
  logic            wptr;
  logic            rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a full buffer can still
  // take a push; occupancy then stays the same.
  assign do_push = push && (!full || pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_state_reader.sv
// aes_state_reader: read-side sequencer for the 16-byte AES state RAM.
// On start it issues 16 reads in linear / ShiftRows / InvShiftRows order,
// absorbs the RAM's one-cycle read latency and streams the bytes out on a
// valid/ready interface.
//   clk, rst_n            clock, synchronous active-low reset
//   start, mode           begin a pass (IDLE only); mode sampled at start
//   raddr, ren, rdata     state RAM read port (rdata valid cycle after ren)
//   out_byte/valid/ready  byte stream; out_last marks byte 15
//   col_data, col_valid   assembled 32-bit columns (AES_READ_COL_EN only)
//   busy, done            pass in progress / one-cycle completion pulse
// Build option: define AES_READ_COL_EN to generate the column assembler;
// otherwise col_data and col_valid are tied to zero.
module aes_state_reader
  import aes_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [7:0]        rdata,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [31:0]       col_data,
  output logic              col_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(AES_STATE_BYTES - 1);

  aes_rd_state_t state;
  logic [1:0]    mode_q;
  logic [3:0]    issue_cnt;
  logic [3:0]    out_cnt;
  logic          rvalid;     // a read was issued last cycle; data is on rdata

  logic [7:0]    buf_dout;
  logic          buf_full;
  logic          buf_empty;
  logic [1:0]    buf_count;
  logic          buf_push;
  logic          buf_pop;
  logic          credit;
  logic          xfer;

  // The returned byte counts as occupancy while it sits on rdata; never let
  // buffered plus in-flight exceed the two buffer slots.
  assign credit = (buf_count + {1'b0, rvalid}) < 2'd2;
  assign ren    = (state == ST_READ) && credit;
  assign raddr  = aes_perm_addr(mode_q, issue_cnt);

  // Fall-through: with the buffer empty the fresh RAM byte is presented
  // directly, which is what gives first valid the cycle after the first read.
  // If it is not taken it is pushed, so the presented byte never changes.
  assign out_valid = !buf_empty || rvalid;
  assign out_byte  = !buf_empty ? buf_dout : (rvalid ? rdata : 8'h00);
  assign xfer      = out_valid && out_ready;
  assign buf_pop   = !buf_empty && out_ready;
  assign buf_push  = rvalid && !(buf_empty && out_ready);
  assign out_last  = out_valid && (out_cnt == LAST_IDX);

  aes_skid_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .din   (rdata),
    .pop   (buf_pop),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 2'b00;
      issue_cnt <= 4'd0;
      out_cnt   <= 4'd0;
      rvalid    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rvalid <= ren;
      done   <= 1'b0;
      if (ren)  issue_cnt <= issue_cnt + 4'd1;
      if (xfer) out_cnt   <= out_cnt + 4'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_READ;
            mode_q <= mode;
            busy   <= 1'b1;
          end
        end
        ST_READ: begin
          if (ren && issue_cnt == LAST_IDX) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (xfer && out_cnt == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_READ_COL_EN
  logic [23:0] col_sh;

  // Column k is complete on the transfer of index 4k+3: the three earlier
  // bytes sit in col_sh with the oldest in the top byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_sh    <= '0;
      col_data  <= '0;
      col_valid <= 1'b0;
    end else begin
      col_valid <= 1'b0;
      if (xfer) begin
        col_sh <= {col_sh[15:0], out_byte};
        if (out_cnt[1:0] == 2'b11) begin
          col_data  <= {col_sh, out_byte};
          col_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign col_data  = 32'h0;
  assign col_valid = 1'b0;
`endif

endmodule

// File: tb/tb_aes_state_reader.sv
// Testbench for aes_state_reader: RAM model holding RAM[i]=i, scoreboard of
// expected bytes (and columns when AES_READ_COL_EN is defined).
module tb_aes_state_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        out_ready = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic [3:0]  raddr;
  logic        ren;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic [31:0] col_data;
  logic        col_valid;
  logic        busy;
  logic        done;

  logic [7:0] ram [16];
  logic [7:0] sh_tab [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                              8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  logic [7:0] inv_tab [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0]  exp_q [$];
  logic [31:0] col_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ren) rdata <= ram[raddr];

  aes_state_reader #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .raddr     (raddr),
    .ren       (ren),
    .rdata     (rdata),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .col_data  (col_data),
    .col_valid (col_valid),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] exp_byte(input logic [1:0] m, input int k);
    case (m)
      2'd1:    return sh_tab[k];
      2'd2:    return inv_tab[k];
      default: return 8'(k);
    endcase
  endfunction

  // One 16-byte pass. rnd: random out_ready; abort_n>0: pulse reset once
  // abort_n bytes have been transferred; poke: pulse start while busy.
  task automatic do_pass(input logic [1:0] m, input bit rnd, input int abort_n,
                         input bit poke, input string tag);
    int n = 0;
    int rens = 0;
    bit fin = 0;
    logic pv = 1'b0;
    logic prdy = 1'b1;
    logic [7:0] pb = 8'h00;
    logic [7:0] e;
`ifdef AES_READ_COL_EN
    logic [31:0] w;
`endif
    exp_q.delete();
    col_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_byte(m, k));
    for (int c = 0; c < 4; c++)
      col_q.push_back({exp_q[4*c], exp_q[4*c+1], exp_q[4*c+2], exp_q[4*c+3]});
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (abort_n > 0 && n == abort_n) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({raddr, ren, out_byte, out_valid, out_last, col_data, col_valid, busy, done} !== '0) begin
          n_err++;
          $display("FAIL %s reset-mid: outputs raddr=%h ren=%b byte=%h v=%b last=%b col=%h cv=%b busy=%b done=%b, want all 0",
                   tag, raddr, ren, out_byte, out_valid, out_last, col_data, col_valid, busy, done);
        end
        exp_q.delete();
        col_q.delete();
        fin = 1;
      end else begin
        start = (cyc == 0) || (poke && cyc == 5);
        mode = (cyc == 0) ? m : ~m;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (cyc == 1) begin
          n_cmp++;
          if (ren !== 1'b1 || busy !== 1'b1 || raddr !== exp_byte(m, 0)[3:0]) begin
            n_err++;
            $display("FAIL %s first-issue: ren=%b busy=%b raddr=%h, want 1 1 %h",
                     tag, ren, busy, raddr, exp_byte(m, 0)[3:0]);
          end
        end
        if (pv && !prdy) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_byte !== pb) begin
            n_err++;
            $display("FAIL %s stall-hold cyc %0d: valid=%b byte=%h, want 1 %h",
                     tag, cyc, out_valid, out_byte, pb);
          end
        end
        n_cmp++;
        if (rens - n > 2) begin
          n_err++;
          $display("FAIL %s occupancy cyc %0d: %0d outstanding, want <= 2", tag, cyc, rens - n);
        end
`ifdef AES_READ_COL_EN
        if (col_valid) begin
          n_cmp++;
          if (col_q.size() == 0) begin
            n_err++;
            $display("FAIL %s column: extra col_valid data=%h, want none", tag, col_data);
          end else begin
            w = col_q.pop_front();
            if (col_data !== w) begin
              n_err++;
              $display("FAIL %s column: got %h want %h", tag, col_data, w);
            end
          end
        end
`else
        n_cmp++;
        if (col_valid !== 1'b0 || col_data !== 32'h0) begin
          n_err++;
          $display("FAIL %s column-off: col_valid=%b col_data=%h, want 0 0", tag, col_valid, col_data);
        end
`endif
        if (out_valid && out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s stream: extra byte %h, want none", tag, out_byte);
          end else begin
            e = exp_q.pop_front();
            if (out_byte !== e || out_last !== (n == 15)) begin
              n_err++;
              $display("FAIL %s stream idx %0d: byte=%h last=%b, want %h %b",
                       tag, n, out_byte, out_last, e, (n == 15));
            end
          end
          n++;
        end
        if (done) begin
          n_cmp++;
          if (n !== 16 || busy !== 1'b0 || (!rnd && cyc != 18)) begin
            n_err++;
            $display("FAIL %s done: cyc=%0d xfers=%0d busy=%b, want cyc 18 (fixed ready) 16 0",
                     tag, cyc, n, busy);
          end
          fin = 1;
        end
        if (ren) rens++;
        pv = out_valid;
        prdy = out_ready;
        pb = out_byte;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: done not seen, xfers=%0d, want 16", tag, n);
    end else if (abort_n == 0) begin
      n_cmp++;
      if (exp_q.size() != 0 || (col_valid === 1'b0 && 0)) begin
        n_err++;
        $display("FAIL %s leftover: %0d bytes missing, want 0", tag, exp_q.size());
      end
`ifdef AES_READ_COL_EN
      n_cmp++;
      if (col_q.size() != 0) begin
        n_err++;
        $display("FAIL %s leftover columns: %0d, want 0", tag, col_q.size());
      end
`endif
    end
    out_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({raddr, ren, out_byte, out_valid, out_last, col_data, col_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset: raddr=%h ren=%b byte=%h v=%b last=%b col=%h cv=%b busy=%b done=%b, want all 0",
               raddr, ren, out_byte, out_valid, out_last, col_data, col_valid, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ren !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle-after-reset: ren=%b busy=%b valid=%b, want 0 0 0", ren, busy, out_valid);
    end
  endtask

  task automatic test_linear;     do_pass(2'd0, 0, 0, 0, "linear");     endtask
  task automatic test_shiftrows;  do_pass(2'd1, 0, 0, 0, "shiftrows");  endtask
  task automatic test_invshift;   do_pass(2'd2, 0, 0, 0, "invshift");   endtask
  task automatic test_mode3;      do_pass(2'd3, 0, 0, 0, "mode3");      endtask
  task automatic test_stall;      do_pass(2'd1, 1, 0, 0, "stall");      endtask
  task automatic test_reset_mid;
    do_pass(2'd0, 0, 7, 0, "abort");
    do_pass(2'd1, 0, 0, 0, "after-abort");
  endtask
  task automatic test_busy_start; do_pass(2'd0, 1, 0, 1, "busy-start"); endtask
  task automatic test_back_to_back;
    do_pass(2'd2, 1, 0, 0, "b2b-a");
    do_pass(2'd0, 0, 0, 0, "b2b-b");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    test_reset();
    test_linear();
    test_shiftrows();
    test_invshift();
    test_mode3();
    test_stall();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
